// File: rtl/frame_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : frame_seq_pkg                                                   |
// | Purpose  : Shared types and widths for the frame strobe sequencer: the    |
// |            sequencer state encoding, the frame index width and the width  |
// |            of the frames-written counter.                                 |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
package frame_seq_pkg;

    localparam int FRAME_IDX_W  = 5;
    localparam int FRAMES_CNT_W = 16;

    // Explicit state codes so the encoding is fixed across tools.
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_STROBE = 2'd2;
    localparam logic [1:0] c_ST_HOLD   = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = c_ST_IDLE,
        SETUP  = c_ST_SETUP,
        STROBE = c_ST_STROBE,
        HOLD   = c_ST_HOLD
    } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_strobe_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : frame_strobe_decoder                                            |
// | Purpose  : Registered one-hot decoder. While i_en is high the register    |
// |            holds a single bit set at position i_idx; otherwise all zero.  |
// |            Registering the output keeps FrameStrobe free of decode        |
// |            glitches.                                                      |
// | Ports    : clk, rst (sync, active-high), i_en, i_idx, o_strobe            |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module frame_strobe_decoder #(
    parameter int MAX_FRAMES_PER_COL = 20,
    parameter int IDX_W              = 5
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_en,
    input  logic [IDX_W-1:0]              i_idx,
    output logic [MAX_FRAMES_PER_COL-1:0] o_strobe
);

    logic [MAX_FRAMES_PER_COL-1:0] w_onehot;
    logic [MAX_FRAMES_PER_COL-1:0] r_strobe;

    // An out-of-range index decodes to all-zero, so the output can never be
    // multi-hot whatever reaches i_idx.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < MAX_FRAMES_PER_COL; i++) begin
            if (i_en && (i_idx == i[IDX_W-1:0])) begin
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_strobe <= '0;
        end else begin
            r_strobe <= w_onehot;
        end
    end

    assign o_strobe = r_strobe;

endmodule
`default_nettype wire

// File: rtl/frame_strobe_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : frame_strobe_sequencer                                          |
// | Purpose  : Accepts (column, frame, word) commands on a valid/ready        |
// |            handshake and writes one configuration frame into this fabric  |
// |            column: FrameData is set up one cycle before a one-hot          |
// |            FrameStrobe pulse of STROBE_CYCLES cycles, then held one cycle. |
// | Ports    : UserCLK, reset (sync, active-high)                              |
// |            s_valid/s_ready/s_col/s_frame/s_data/s_parity - command in      |
// |            FrameData, FrameStrobe - column frame write interface           |
// |            busy, err_addr, err_parity, frames_written - status             |
// | Options  : FRAME_PARITY_CHECK_EN - reject commands whose s_parity does not |
// |            match the even parity of s_data (sets sticky err_parity).       |
// | Revision : 1.0 - initial release                                          |
// +----------------------------------------------------------------------------+
module frame_strobe_sequencer
    import frame_seq_pkg::*;
#(
    parameter int MAX_FRAMES_PER_COL = 20,
    parameter int FRAME_BITS_PER_ROW = 32,
    parameter int COL_SELECT_WIDTH   = 5,
    parameter int COL_INDEX          = 0,
    parameter int STROBE_CYCLES      = 1
) (
    input  logic                          UserCLK,
    input  logic                          reset,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [COL_SELECT_WIDTH-1:0]   s_col,
    input  logic [FRAME_IDX_W-1:0]        s_frame,
    input  logic [FRAME_BITS_PER_ROW-1:0] s_data,
    input  logic                          s_parity,
    output logic [FRAME_BITS_PER_ROW-1:0] FrameData,
    output logic [MAX_FRAMES_PER_COL-1:0] FrameStrobe,
    output logic                          busy,
    output logic                          err_addr,
    output logic                          err_parity,
    output logic [FRAMES_CNT_W-1:0]       frames_written
);

    localparam logic [3:0]                  c_STROBE_LOAD = 4'(STROBE_CYCLES - 1);
    localparam logic [COL_SELECT_WIDTH-1:0] c_COL         = COL_SELECT_WIDTH'(COL_INDEX);
    localparam logic [FRAME_IDX_W:0]        c_MAX_FRAMES  = (FRAME_IDX_W + 1)'(MAX_FRAMES_PER_COL);

    state_t                        r_state;
    state_t                        w_state_next;
    logic [FRAME_BITS_PER_ROW-1:0] r_frame_data;
    logic [FRAME_IDX_W-1:0]        r_index;
    logic [3:0]                    r_strobe_cnt;
    logic [FRAMES_CNT_W-1:0]       r_frames_written;
    logic                          r_err_addr;

    logic w_xfer;
    logic w_col_hit;
    logic w_addr_ok;
    logic w_parity_ok;
    logic w_accept;
    logic w_strobe_done;

    assign w_xfer        = s_valid && (r_state == IDLE);
    assign w_col_hit     = (s_col == c_COL);
    assign w_addr_ok     = ({1'b0, s_frame} < c_MAX_FRAMES);
    assign w_strobe_done = (r_state == STROBE) && (r_strobe_cnt == '0);

`ifdef FRAME_PARITY_CHECK_EN
    logic r_err_parity;

    assign w_parity_ok = ((^s_data) == s_parity);

    // Column and address checks win: only a command that passed both can
    // raise a parity error.
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            r_err_parity <= 1'b0;
        end else if (w_xfer && w_col_hit && w_addr_ok && !w_parity_ok) begin
            r_err_parity <= 1'b1;
        end
    end

    assign err_parity = r_err_parity;
`else
    logic w_parity_unused;

    assign w_parity_unused = s_parity;
    assign w_parity_ok     = 1'b1;
    assign err_parity      = 1'b0;
`endif

    assign w_accept = w_xfer && w_col_hit && w_addr_ok && w_parity_ok;

    // State register
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = SETUP;
            SETUP:   w_state_next = STROBE;
            STROBE:  if (r_strobe_cnt == '0) w_state_next = HOLD;
            HOLD:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Datapath, strobe length counter and status
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            r_frame_data     <= '0;
            r_index          <= '0;
            r_strobe_cnt     <= '0;
            r_frames_written <= '0;
            r_err_addr       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_frame_data <= s_data;
                r_index      <= s_frame;
            end

            // Loaded during SETUP so it counts the STROBE cycles down to zero.
            if (r_state == SETUP) begin
                r_strobe_cnt <= c_STROBE_LOAD;
            end else if ((r_state == STROBE) && (r_strobe_cnt != '0)) begin
                r_strobe_cnt <= r_strobe_cnt - 4'd1;
            end

            // Counted only on the normal exit from STROBE; wraps naturally.
            if (w_strobe_done) begin
                r_frames_written <= r_frames_written + 1'b1;
            end

            if (w_xfer && w_col_hit && !w_addr_ok) begin
                r_err_addr <= 1'b1;
            end
        end
    end

    // The decoder is fed the next state so its registered output lines up
    // exactly with the STROBE state.
    frame_strobe_decoder #(
        .MAX_FRAMES_PER_COL (MAX_FRAMES_PER_COL),
        .IDX_W              (FRAME_IDX_W)
    ) u_decoder (
        .clk      (UserCLK),
        .rst      (reset),
        .i_en     (w_state_next == STROBE),
        .i_idx    (r_index),
        .o_strobe (FrameStrobe)
    );

    assign s_ready        = (r_state == IDLE);
    assign busy           = (r_state != IDLE);
    assign FrameData      = r_frame_data;
    assign err_addr       = r_err_addr;
    assign frames_written = r_frames_written;

endmodule
`default_nettype wire
